sched_insert_search: RTL and testbench
======================================

SCHED_INSERT_SEARCH -- requirements
Module: sched_insert_search

Interface
REQ-001 Parameter DEPTH, default 16: table entries; SHALL be a power of two, 2..256.
REQ-002 Parameter KEY_W, default 32: key width, unsigned.
REQ-003 Parameter TAG_W, default 4: request tag width, passed through unchanged.
REQ-004 Localparam IDX_W = $clog2(DEPTH)+1: width of positions and counts (0..DEPTH).
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_valid  in  1  search request present.
REQ-008 req_ready  out  1  block idle, can accept.
REQ-009 req_key  in  KEY_W  key to place.
REQ-010 req_tag  in  TAG_W  caller tag.
REQ-011 tbl_keys  in  DEPTH*KEY_W  ascending-sorted table, entry i at bits [i*KEY_W +: KEY_W].
REQ-012 tbl_count  in  IDX_W  number of valid entries from index 0.
REQ-013 rsp_valid  out  1  result present.
REQ-014 rsp_ready  in  1  consumer accepts result.
REQ-015 rsp_pos  out  IDX_W  insertion index.
REQ-016 rsp_key  out  KEY_W  echoed req_key.
REQ-017 rsp_tag  out  TAG_W  echoed req_tag.

Function
REQ-018 The block SHALL return the upper-bound position: the smallest i < n with tbl[i] > req_key, else n, where n = min(tbl_count, DEPTH); equal keys therefore insert after existing equals (FIFO among equal priority).
REQ-019 Entries at index >= n SHALL never influence the result.
REQ-020 FSM states SHALL be IDLE, SEARCH, DONE; req_ready = (state == IDLE); rsp_valid = (state == DONE).
REQ-021 On accept (req_valid && req_ready), the block SHALL latch req_key, req_tag, lo = 0, hi = n, and enter SEARCH.
REQ-022 In SEARCH, each cycle: if lo == hi then rsp_pos <= lo and enter DONE; else mid = (lo+hi)>>1, and if req_key >= tbl[mid] then lo <= mid+1, else hi <= mid.
REQ-023 lo, hi, mid SHALL be IDX_W wide so that hi = DEPTH does not overflow.
REQ-024 Search SHALL take at most ceil(log2(n+1)) update cycles; accept-to-rsp_valid SHALL be at most ceil(log2(n+1))+1 clock edges (6 for n = 16).
REQ-025 tbl_keys and tbl_count SHALL be held stable by the driver from accept until rsp handshake; the block does not snapshot the table.
REQ-026 In DONE, rsp_pos, rsp_key and rsp_tag SHALL hold stable until rsp_valid && rsp_ready, then the FSM returns to IDLE.
REQ-027 A new request SHALL NOT be accepted in the same cycle as a response handshake; req_ready rises the cycle after (one request in flight).
REQ-028 tbl_count > DEPTH SHALL be clamped to DEPTH.

Reset
REQ-029 rst high at a clock edge SHALL force IDLE, and clear lo, hi, rsp_pos, rsp_key and rsp_tag to 0, in any state including mid-SEARCH and DONE; any in-flight request is discarded with no response.
REQ-030 After reset: req_ready = 1 and rsp_valid = 0 from the first edge with rst low.

Configuration
REQ-031 Macro SCHED_SEARCH_FASTPATH_EN, when defined, SHALL add a fast path at accept: if n == 0 or req_key < tbl[0], then rsp_pos = 0; if req_key >= tbl[n-1], then rsp_pos = n; in both cases the FSM goes IDLE->DONE directly, with rsp_valid after 1 edge.
REQ-032 Without SCHED_SEARCH_FASTPATH_EN, every request SHALL pass through SEARCH; results SHALL be identical in both builds, and only latency differs.

Verification
REQ-033 DEPTH=16, table 10,20,...,160, count=16, key 55 -> rsp_pos=5, rsp_valid within 6 edges of accept, rsp_tag echoed.
REQ-034 Same table, key 20 -> rsp_pos=2; key 160 -> rsp_pos=16; key 5 -> rsp_pos=0 (1 edge with FASTPATH, search path without).
REQ-035 count=0, any key -> rsp_pos=0; count=3 with garbage in entries 3..15, key 25 -> rsp_pos=2; count=20 -> treated as 16.
REQ-036 rsp_ready held low 10 cycles in DONE -> rsp_* stable and req_ready=0 throughout; after handshake, req_ready=1 on the next cycle.
REQ-037 rst asserted during the 3rd SEARCH cycle -> next cycle IDLE, rsp_valid=0, outputs zero; a following request (key 55) -> rsp_pos=5.

Source files
------------

// File: rtl/sched_insert_search_if.sv
// sched_insert_search_if: request/response handshake plus the sorted table the search reads.
interface sched_insert_search_if #(
  parameter int DEPTH = 16,
  parameter int KEY_W = 32,
  parameter int TAG_W = 4
);
  localparam int IDX_W = $clog2(DEPTH) + 1;
  logic                   req_valid;
  logic                   req_ready;
  logic [KEY_W-1:0]       req_key;
  logic [TAG_W-1:0]       req_tag;
  logic [DEPTH*KEY_W-1:0] tbl_keys;
  logic [IDX_W-1:0]       tbl_count;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDX_W-1:0]       rsp_pos;
  logic [KEY_W-1:0]       rsp_key;
  logic [TAG_W-1:0]       rsp_tag;
  modport master (
    output req_valid, req_key, req_tag, tbl_keys, tbl_count, rsp_ready,
    input  req_ready, rsp_valid, rsp_pos, rsp_key, rsp_tag
  );
  modport slave (
    input  req_valid, req_key, req_tag, tbl_keys, tbl_count, rsp_ready,
    output req_ready, rsp_valid, rsp_pos, rsp_key, rsp_tag
  );
endinterface

// File: rtl/sched_insert_search.sv
// sched_insert_search: binary search for the upper-bound insertion slot in a sorted table.
// Optional macro SCHED_SEARCH_FASTPATH_EN resolves out-of-range keys directly at accept.
module sched_insert_search #(
  parameter int DEPTH = 16,
  parameter int KEY_W = 32,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic rst,
  sched_insert_search_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH) + 1;
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] lo, hi, n, mid, pos, fast_pos;
  logic [IDX_W:0]   sum;
  logic [KEY_W-1:0] key;
  logic [KEY_W-1:0] tbl [DEPTH];
  logic [TAG_W-1:0] tag;
  logic             fast, ge_mid;
  for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
    assign tbl[i] = bus.tbl_keys[i*KEY_W +: KEY_W];
  end
  assign n      = bus.tbl_count > IDX_W'(DEPTH) ? IDX_W'(DEPTH) : bus.tbl_count;
  assign sum    = {1'b0, lo} + {1'b0, hi};
  assign mid    = sum[IDX_W:1];
  // lo < hi whenever mid is used, so mid never reaches DEPTH
  assign ge_mid = key >= tbl[mid[IDX_W-2:0]];
`ifdef SCHED_SEARCH_FASTPATH_EN
  logic [IDX_W-1:0] last;
  logic             below;
  assign last     = n - IDX_W'(1);
  assign below    = n == '0 || bus.req_key < tbl[0];
  assign fast     = below || bus.req_key >= tbl[last[IDX_W-2:0]];
  assign fast_pos = below ? '0 : n;
`else
  assign fast     = 1'b0;
  assign fast_pos = '0;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    state_n = state == IDLE   ? (bus.req_valid ? (fast ? DONE : SEARCH) : IDLE)
            : state == SEARCH ? (lo == hi ? DONE : SEARCH)
            : (bus.rsp_ready ? IDLE : DONE);
  end
  always_comb begin
    bus.req_ready = state == IDLE;
    bus.rsp_valid = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lo  <= '0;
      hi  <= '0;
      pos <= '0;
      key <= '0;
      tag <= '0;
    end else if (state == IDLE && bus.req_valid) begin
      key <= bus.req_key;
      tag <= bus.req_tag;
      lo  <= '0;
      hi  <= n;
      if (fast) pos <= fast_pos;
    end else if (state == SEARCH) begin
      if (lo == hi) pos <= lo;
      else if (ge_mid) lo <= mid + IDX_W'(1);
      else hi <= mid;
    end
  end
  assign bus.rsp_pos = pos;
  assign bus.rsp_key = key;
  assign bus.rsp_tag = tag;
endmodule

// File: tb/tb_sched_insert_search.sv
// tb_sched_insert_search: directed vectors, handshake/reset sequences and random tables
// checked against a linear-scan upper-bound model.
module tb_sched_insert_search;
  localparam int DEPTH = 16;
  localparam int KEY_W = 32;
  localparam int TAG_W = 4;
  logic clk = 0;
  logic rst = 1;
  int n_chk = 0;
  int n_fail = 0;
  logic [KEY_W-1:0] tb [DEPTH];
  sched_insert_search_if #(.DEPTH(DEPTH), .KEY_W(KEY_W), .TAG_W(TAG_W)) bus ();
  sched_insert_search #(.DEPTH(DEPTH), .KEY_W(KEY_W), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  typedef struct {
    int          cnt;
    bit          garb;
    logic [31:0] key;
    int          pos;
  } vec_t;
  vec_t vecs [13] = '{
    '{16, 0, 55, 5}, '{16, 0, 20, 2}, '{16, 0, 160, 16}, '{16, 0, 5, 0},
    '{16, 0, 10, 1}, '{16, 0, 159, 15}, '{16, 0, 0, 0}, '{0, 0, 55, 0},
    '{0, 0, 0, 0}, '{3, 1, 25, 2}, '{3, 1, 35, 3}, '{20, 0, 55, 5},
    '{20, 0, 200, 16}
  };
  function automatic void chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction
  function automatic int ref_pos(int cnt, logic [31:0] key);
    int n = cnt > DEPTH ? DEPTH : cnt;
    for (int i = 0; i < n; i++)
      if (tb[i] > key) return i;
    return n;
  endfunction
  function automatic int lat_bound(int cnt);
    int n = cnt > DEPTH ? DEPTH : cnt;
    int b = 0;
    while ((1 << b) < n + 1) b++;
    return b + 1;
  endfunction
  task automatic load(input int cnt);
    for (int i = 0; i < DEPTH; i++) bus.tbl_keys[i*KEY_W +: KEY_W] = tb[i];
    bus.tbl_count = 5'(cnt);
  endtask
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("rsp_valid_seen", bus.rsp_valid, 1);
  endtask
  task automatic xact(input logic [31:0] key, input logic [3:0] tag, input int stall,
                      output int pos, output int lat);
    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1;
    bus.req_key   = key;
    bus.req_tag   = tag;
    @(posedge clk);
    #1 bus.req_valid = 0;
    wait_rsp(lat);
    pos = int'(bus.rsp_pos);
    chk("rsp_key_echo", bus.rsp_key, key);
    chk("rsp_tag_echo", bus.rsp_tag, tag);
    repeat (stall) @(posedge clk);
    @(negedge clk) bus.rsp_ready = 1;
    @(posedge clk);
    #1 bus.rsp_ready = 0;
  endtask
  initial begin
    int pos, lat, cnt;
    logic [31:0] v, key, k0;
    logic [3:0] t0;
    logic [4:0] p0;
    bus.req_valid = 0;
    bus.req_key   = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 0;
    for (int i = 0; i < DEPTH; i++) tb[i] = 32'((i + 1) * 10);
    load(16);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_req_ready", bus.req_ready, 1);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_pos", bus.rsp_pos, 0);
    chk("reset_rsp_key", bus.rsp_key, 0);
    chk("reset_rsp_tag", bus.rsp_tag, 0);
    foreach (vecs[i]) begin
      for (int j = 0; j < DEPTH; j++)
        tb[j] = (vecs[i].garb && j >= vecs[i].cnt) ? 32'd0 : 32'((j + 1) * 10);
      load(vecs[i].cnt);
      xact(vecs[i].key, 4'(i), 0, pos, lat);
      chk($sformatf("vec%0d_pos", i), pos, vecs[i].pos);
      chk($sformatf("vec%0d_lat_ok", i), lat <= lat_bound(vecs[i].cnt), 1);
`ifdef SCHED_SEARCH_FASTPATH_EN
      if (vecs[i].key == 5) chk("fastpath_lat", lat, 0);
`endif
    end
    for (int j = 0; j < DEPTH; j++) tb[j] = 32'((j + 1) * 10);
    load(16);
    @(negedge clk);
    bus.req_valid = 1;
    bus.req_key   = 55;
    bus.req_tag   = 4'hA;
    @(posedge clk);
    #1 bus.req_valid = 0;
    wait_rsp(lat);
    p0 = bus.rsp_pos;
    k0 = bus.rsp_key;
    t0 = bus.rsp_tag;
    chk("stall_pos", p0, 5);
    chk("stall_tag", t0, 4'hA);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_ready_low", bus.req_ready, 0);
      chk("stall_pos_hold", bus.rsp_pos, p0);
      chk("stall_key_hold", bus.rsp_key, k0);
      chk("stall_tag_hold", bus.rsp_tag, t0);
    end
    @(negedge clk);
    bus.rsp_ready = 1;
    bus.req_valid = 1;
    bus.req_key   = 20;
    chk("no_accept_in_handshake", bus.req_ready, 0);
    @(posedge clk);
    #1;
    bus.rsp_ready = 0;
    bus.req_valid = 0;
    chk("post_hs_rsp_valid", bus.rsp_valid, 0);
    chk("post_hs_req_ready", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1;
    bus.req_key   = 55;
    bus.req_tag   = 4'h9;
    @(posedge clk);
    #1 bus.req_valid = 0;
    chk("search_busy", bus.req_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
    chk("mid_search_no_rsp", bus.rsp_valid, 0);
    @(posedge clk);
    #1 rst = 0;
    chk("mid_rst_req_ready", bus.req_ready, 1);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_pos", bus.rsp_pos, 0);
    chk("mid_rst_key", bus.rsp_key, 0);
    chk("mid_rst_tag", bus.rsp_tag, 0);
    xact(55, 4'h3, 0, pos, lat);
    chk("after_rst_pos", pos, 5);
    for (int it = 0; it < 150; it++) begin
      cnt = $urandom_range(0, 20);
      v = $urandom_range(0, 20);
      for (int j = 0; j < DEPTH; j++) begin
        if (j < cnt) begin
          tb[j] = v;
          v += $urandom_range(0, 3);
        end else tb[j] = $urandom;
      end
      load(cnt);
      key = $urandom_range(0, v + 5);
      xact(key, 4'($urandom), $urandom_range(0, 2), pos, lat);
      chk("rand_pos", pos, ref_pos(cnt, key));
      chk("rand_lat_ok", lat <= lat_bound(cnt), 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
